// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter that time-shares one external combinational ALU among
// NUM_REQ requesters: capture operands, execute for one cycle, then hold the result until the owner accepts it.
module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [XLEN*NUM_REQ-1:0] req_a,
    input  logic [XLEN*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [XLEN-1:0]         resp_result,
    output logic                    resp_err,
    output logic [3:0]              alu_op,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_result,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] owner_reg;
    logic [3:0]       op_reg;
    logic [XLEN-1:0]  a_reg, b_reg, result_reg;
    logic             err_flag_reg, err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [3:0]      op_arr [NUM_REQ];
    logic [XLEN-1:0] a_arr  [NUM_REQ];
    logic [XLEN-1:0] b_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign op_arr[gi] = req_op[4*gi +: 4];
            assign a_arr[gi]  = req_a[XLEN*gi +: XLEN];
            assign b_arr[gi]  = req_b[XLEN*gi +: XLEN];
        end
    endgenerate

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
            4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: op_is_legal = 1'b1;
            default:                                      op_is_legal = 1'b0;
        endcase
    endfunction

    // Rotating-priority search: first valid requester at or after rr_ptr.
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    logic             accept;
    logic             resp_done;
    logic [3:0]       sel_op;
    logic             sel_legal;
    logic [PTR_W-1:0] ptr_next;

    assign accept    = (state_reg == S_IDLE) && grant_found;
    assign resp_done = (state_reg == S_RESP) && resp_ready[owner_reg];
    assign sel_op    = op_arr[grant_idx];
    assign sel_legal = op_is_legal(sel_op);
    assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  if (resp_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            op_reg       <= 4'b0000;
            a_reg        <= '0;
            b_reg        <= '0;
            err_flag_reg <= 1'b0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Undefined opcodes execute as ADD and are flagged in the response.
                op_reg       <= sel_legal ? sel_op : 4'b0000;
                err_flag_reg <= ~sel_legal;
                a_reg        <= a_arr[grant_idx];
                b_reg        <= b_arr[grant_idx];
                owner_reg    <= grant_idx;
                rr_ptr_reg   <= ptr_next;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= alu_result;
                err_reg    <= err_flag_reg;
            end
            if (resp_done && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
        if (state_reg == S_RESP) resp_valid[owner_reg] = 1'b1;
    end

    assign resp_result = result_reg;
    assign resp_err    = (state_reg == S_RESP) && err_reg;
    assign alu_op      = op_reg;
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign busy        = (state_reg != S_IDLE);
    assign op_count    = cnt_reg;
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one combinational ALU (opcodes per `alu_pkg::alu_op_t`) among NUM_REQ requesters.
- Each requester uses valid/ready request and response channels.
- The block latches the winner's operands, drives the ALU for one execute cycle, registers the result, and holds it until the owner accepts it.
- It sits between the issue/microcode agents and the shared ALU instance in the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XLEN, 32, operand/result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero).
- req_op  in  4*NUM_REQ  per-requester opcode (`alu_op_t` encoding), slice i = [4i+3:4i].
- req_a  in  XLEN*NUM_REQ  per-requester operand A.
- req_b  in  XLEN*NUM_REQ  per-requester operand B.
- resp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero).
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_result  out  XLEN  registered result, shared bus, meaningful for the asserted resp_valid bit.
- resp_err  out  1  set with resp_valid when the request opcode was not a defined `alu_op_t` value.
- alu_op  out  4  opcode to shared ALU.
- alu_a  out  XLEN  operand A to shared ALU.
- alu_b  out  XLEN  operand B to shared ALU.
- alu_result  in  XLEN  combinational ALU result for alu_op/alu_a/alu_b.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  completed responses, saturating at all-ones.

Behaviour:
- FSM states are IDLE, EXEC and RESP.
- Reset (rst=1 at a clock edge, from any state):
  - state=IDLE.
  - rr_ptr=0.
  - op_count=0.
  - Operand/op/result/err registers cleared to 0.
  - All outputs 0: req_ready, resp_valid, resp_err, busy, alu_op=ALU_ADD (4'b0000), alu_a, alu_b.
  - A reset in EXEC or RESP drops the in-flight operation; no response is produced.
- IDLE:
  - Arbiter picks the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is asserted combinationally only for that winner; all other req_ready bits are 0.
  - Outside IDLE, req_ready=0.
  - On req_valid[i]&req_ready[i]:
    - Capture req_op/req_a/req_b slice i and owner=i.
    - rr_ptr<=(i+1) mod NUM_REQ.
    - Go to EXEC.
  - No request: stay in IDLE, rr_ptr unchanged.
- Opcode check:
  - Legal codes are 0000, 1000, 0111, 0110, 0100, 0001, 0101, 1101, 0010, 0011.
  - Any other code is captured as ALU_ADD with err flag=1.
- EXEC (exactly 1 cycle):
  - alu_op/alu_a/alu_b driven from captured registers.
  - At the clock edge, result_reg<=alu_result and err_reg<=err flag; go to RESP.
  - alu_* outputs hold their captured values in EXEC and RESP and return to 0 only on reset.
- RESP:
  - resp_valid[owner]=1, resp_result=result_reg, resp_err=err_reg.
  - These are held stable until resp_ready[owner]=1.
  - resp_ready on non-owner bits is ignored.
  - On handshake: op_count increments (saturates at 2^CNT_W-1); go to IDLE.
- Latency:
  - Request accepted at edge T; result captured at edge T+1; resp_valid high in the cycle after T+1.
  - Minimum initiation interval is 3 cycles: IDLE accept, EXEC, RESP with same-cycle resp_ready.
- Requester rules:
  - Requesters keep req_valid and operands stable until accepted.
  - A requester may deassert req_valid before acceptance; it is then simply not picked.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...

Test Plan:
- Single op: req 2 valid, op=ALU_SUB, a=10, b=3, rr_ptr=0.
  - req_ready[2]=1 in accept cycle.
  - resp_valid=4'b0100, resp_result=7, resp_err=0, two cycles after accept.
  - op_count=1 after handshake.
- Round robin: all 4 valid continuously with ALU_ADD a=i, b=1, resp_ready tied 1.
  - Grant order 0,1,2,3,0.
  - Results 1,2,3,4,1.
  - Each grant 3 cycles apart.
- Backpressure: ALU_SRA a=32'h8000_0000, b=4, owner=1, resp_ready[1]=0 for 5 cycles.
  - resp_valid[1] and resp_result=32'hF800_0000 stable for 5 cycles.
  - req_ready=0 throughout.
  - resp_ready[0]=1 during this window does not complete the response.
- Illegal opcode: op=4'b1111, a=5, b=6.
  - alu_op=0000 in EXEC.
  - resp_result=11, resp_err=1.
- Reset mid-operation: assert rst during EXEC and, separately, during RESP.
  - Next cycle: all outputs 0, busy=0, no resp_valid.
  - op_count=0.
  - The next request is granted from requester 0 priority.
- Counter saturation: CNT_W=2, complete 5 operations.
  - op_count sequence 1,2,3,3,3.
